// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request front-end: opcodes, FSM encoding, result width.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

  function automatic int unsigned res_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, else lowest below it.
module alu_rr_pick #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win_idx_c,
  output logic            win_vld_c
);

  logic          hi_vld;
  logic          lo_vld;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Descending scan so the lowest qualifying index in each half wins.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IW'(i) >= ptr) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IW'(i);
        end
      end
    end
  end

  assign win_vld_c = hi_vld | lo_vld;
  assign win_idx_c = hi_vld ? hi_idx : lo_idx;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one multi-cycle ALU core between NREQ requesters: round-robin grant,
// operand latch, bgn/stop handshake with the core, and timeout abort.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [W*NREQ-1:0]   req_a,
  input  logic [W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [2*W-1:0]      result,
  output logic                busy,
  output logic                alu_bgn,
  output logic [1:0]          alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic                alu_stop,
  input  logic [2*W-1:0]      alu_result
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam int unsigned RW = res_width(W);

  logic [ST_W-1:0] state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   grant, grant_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] done_nxt;
  logic            err_nxt;
  logic [RW-1:0]   result_nxt;
  logic            busy_nxt;
  logic            bgn_nxt;
  logic [1:0]      op_nxt;
  logic [W-1:0]    a_nxt;
  logic [W-1:0]    b_nxt;

  logic [IW-1:0]   win_idx_c;
  logic            win_vld_c;
  logic [NREQ-1:0] grant_oh;
  logic [1:0]      op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];

  alu_rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win_idx_c (win_idx_c),
    .win_vld_c (win_vld_c)
  );

  // Unpack the per-requester buses for indexed selection.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      a_arr[i]    = req_a[W*i +: W];
      b_arr[i]    = req_b[W*i +: W];
      grant_oh[i] = (grant == IW'(i));
    end
  end

  // Next-state and next-output logic; outputs take the value of the state being entered.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    cnt_nxt    = cnt;
    op_nxt     = alu_op;
    a_nxt      = alu_a;
    b_nxt      = alu_b;
    done_nxt   = '0;
    err_nxt    = 1'b0;
    result_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (win_vld_c) begin
          grant_nxt = win_idx_c;
          op_nxt    = op_arr[win_idx_c];
          a_nxt     = a_arr[win_idx_c];
          b_nxt     = b_arr[win_idx_c];
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_stop) begin
          result_nxt = alu_result;
          done_nxt   = grant_oh;
          state_nxt  = ST_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          done_nxt  = grant_oh;
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RESP: begin
        ptr_nxt   = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    bgn_nxt  = (state_nxt == ST_ISSUE);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant   <= '0;
      cnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      alu_bgn <= 1'b0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      grant   <= grant_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      result  <= result_nxt;
      busy    <= busy_nxt;
      alu_bgn <= bgn_nxt;
      alu_op  <= op_nxt;
      alu_a   <= a_nxt;
      alu_b   <= b_nxt;
    end
  end

endmodule
